uart_tx: RTL

Serial UART transmitter, the transmit-side counterpart to the team's UART receiver. Accepts parallel words over a valid/ready handshake and serializes each as one start bit, WIDTH data bits MSB-first, and one stop bit. Bit period is exactly DIVISOR clk cycles. A one-entry holding register allows back-to-back frames with no idle gap on the line.

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Parallel-word handshake between a producer and the UART transmitter.
// A transfer happens on any cycle where i_data_valid && o_ready.
interface uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_data;
  logic             i_data_valid;
  logic             o_ready;

  modport master (output i_data, output i_data_valid, input o_ready);
  modport slave  (input i_data, input i_data_valid, output o_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits MSB-first, stop bit, DIVISOR clks per bit.
// A one-word holding register lets the next frame start right after the current stop bit.
module uart_tx #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 100
) (
  input  logic      clk,
  input  logic      i_reset,
  uart_tx_if.slave  bus,
  output logic      o_tx,
  output logic      o_busy
);
  localparam int BAUD_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BIT_W  = $clog2(WIDTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              ready_q;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  logic handshake;
  logic rollover;
  logic load_point;

  assign handshake  = bus.i_data_valid && ready_q;
  assign rollover   = (baud_q == BAUD_LAST);
  // A new frame may begin from IDLE or on the final cycle of a stop bit.
  assign load_point = (state_q == S_IDLE) || ((state_q == S_STOP) && rollover);
  assign bus.o_ready = ready_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      baud_q      <= '0;
      bit_q       <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    baud_d      = baud_q;
    bit_d       = bit_q;

    if (state_q != S_IDLE) begin
      baud_d = rollover ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_START: begin
        if (rollover) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (rollover) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (rollover) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // A pending word has priority; otherwise a same-cycle handshake bypasses the holding register.
    if (load_point && hold_full_q) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      baud_d      = '0;
      state_d     = S_START;
    end else if (load_point && handshake) begin
      shift_d = bus.i_data;
      baud_d  = '0;
      state_d = S_START;
    end else if (handshake) begin
      hold_d      = bus.i_data;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    o_tx   = 1'b1;
    o_busy = (state_q != S_IDLE);
    case (state_q)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = shift_q[WIDTH-1];
      default: o_tx = 1'b1;
    endcase
  end
endmodule
